// File: rtl/hpi_responder.sv
// Host-port responder: host-visible DATA/MAILBOX/ADDRESS/STATUS registers over a
// strobe-sampled bus, a dual-ported 16-bit RAM shared with local logic, and two mailboxes.
module hpi_responder #(
   parameter int ADDR_W = 8
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [1:0]        OTG_ADDR,
   input  logic              OTG_CS_N,
   input  logic              OTG_RD_N,
   input  logic              OTG_WR_N,
   input  logic [15:0]       OTG_DATA_IN,
   output logic [15:0]       OTG_DATA_OUT,
   output logic              OTG_DATA_OE,
   output logic              OTG_INT,
   input  logic [ADDR_W-1:0] loc_addr,
   input  logic [15:0]       loc_wdata,
   input  logic              loc_we,
   output logic [15:0]       loc_rdata,
   input  logic [15:0]       mbx_out_data,
   input  logic              mbx_out_wr,
   output logic [15:0]       mbx_in_data,
   output logic              mbx_in_valid,
   input  logic              mbx_in_ack
);

   localparam logic [1:0] SEL_DATA    = 2'd0;
   localparam logic [1:0] SEL_MAILBOX = 2'd1;
   localparam logic [1:0] SEL_ADDRESS = 2'd2;
   localparam logic [1:0] SEL_STATUS  = 2'd3;

   logic              r_rd_n;
   logic              r_wr_n;
   logic              r_rd_blk;
   logic              r_wr_blk;
   logic [15:0]       r_haddr;
   logic [15:0]       r_data_out;
   logic [15:0]       r_loc_rdata;
   logic [15:0]       r_mbx_in_data;
   logic              r_mbx_in_valid;
   logic              r_ovf;
   logic [15:0]       r_mbx_out;
   logic              r_out_full;
   logic              r_int;
   logic [15:0]       r_ram [0:(1 << ADDR_W) - 1];

   logic              w_wr_ev;
   logic              w_rd_ev;
   logic [ADDR_W-1:0] w_host_word;
   logic              w_host_ram_we;
   logic              w_mbx_in_wr;
   logic              w_mbx_out_rd;
   logic              w_full_next;
   logic [15:0]       w_rd_mux;

   // The block flags stay set after reset until each strobe is seen high, so a
   // strobe held low through reset cannot produce an event when reset releases.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_rd_n   <= 1'b1;
         r_wr_n   <= 1'b1;
         r_rd_blk <= 1'b1;
         r_wr_blk <= 1'b1;
      end else begin
         r_rd_n <= OTG_RD_N;
         r_wr_n <= OTG_WR_N;
         if (OTG_RD_N) r_rd_blk <= 1'b0;
         if (OTG_WR_N) r_wr_blk <= 1'b0;
      end
   end

   assign w_wr_ev = ~OTG_CS_N & ~OTG_WR_N & r_wr_n & ~r_wr_blk;
   // A read strobe overlapping a write strobe is treated as the write alone.
   assign w_rd_ev = ~OTG_CS_N & ~OTG_RD_N & OTG_WR_N & r_rd_n & ~r_rd_blk;

   assign w_host_word   = r_haddr[ADDR_W:1];
   assign w_host_ram_we = w_wr_ev & (OTG_ADDR == SEL_DATA);
   assign w_mbx_in_wr   = w_wr_ev & (OTG_ADDR == SEL_MAILBOX);
   assign w_mbx_out_rd  = w_rd_ev & (OTG_ADDR == SEL_MAILBOX);
   assign w_full_next   = mbx_out_wr ? 1'b1 : (w_mbx_out_rd ? 1'b0 : r_out_full);

   // Host wins a same-word collision with the local write port.
   always_ff @(posedge Clk) begin
      if (w_host_ram_we) begin
         r_ram[w_host_word] <= OTG_DATA_IN;
      end
      if (loc_we && !(w_host_ram_we && (w_host_word == loc_addr))) begin
         r_ram[loc_addr] <= loc_wdata;
      end
   end

   always_comb begin
      w_rd_mux = 16'h0000;
      case (OTG_ADDR)
         SEL_DATA:    w_rd_mux = r_ram[w_host_word];
         SEL_MAILBOX: w_rd_mux = r_mbx_out;
         SEL_ADDRESS: w_rd_mux = r_haddr;
         SEL_STATUS:  w_rd_mux = {13'b0, r_ovf, r_out_full, r_mbx_in_valid};
         default:     w_rd_mux = 16'h0000;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_data_out <= 16'h0000;
      end else if (w_rd_ev) begin
         r_data_out <= w_rd_mux;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_loc_rdata <= 16'h0000;
      end else begin
         r_loc_rdata <= r_ram[loc_addr];
      end
   end

   // Every DATA access advances the byte address by one word.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_haddr <= 16'h0000;
      end else if (w_wr_ev && (OTG_ADDR == SEL_ADDRESS)) begin
         r_haddr <= OTG_DATA_IN;
      end else if ((w_wr_ev || w_rd_ev) && (OTG_ADDR == SEL_DATA)) begin
         r_haddr <= r_haddr + 16'd2;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_mbx_in_data  <= 16'h0000;
         r_mbx_in_valid <= 1'b0;
         r_ovf          <= 1'b0;
      end else begin
         if (w_mbx_in_wr) begin
            r_mbx_in_data  <= OTG_DATA_IN;
            r_mbx_in_valid <= 1'b1;
         end else if (mbx_in_ack) begin
            r_mbx_in_valid <= 1'b0;
         end
         // An ack landing with the overwrite means nothing was lost.
         if (w_mbx_in_wr && r_mbx_in_valid && !mbx_in_ack) begin
            r_ovf <= 1'b1;
         end else if (w_wr_ev && (OTG_ADDR == SEL_STATUS) && OTG_DATA_IN[2]) begin
            r_ovf <= 1'b0;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_mbx_out  <= 16'h0000;
         r_out_full <= 1'b0;
         r_int      <= 1'b0;
      end else begin
         if (mbx_out_wr) r_mbx_out <= mbx_out_data;
         r_out_full <= w_full_next;
         r_int      <= w_full_next;
      end
   end

   assign OTG_DATA_OUT = r_data_out;
   assign OTG_DATA_OE  = ~OTG_CS_N & ~OTG_RD_N;
   assign OTG_INT      = r_int;
   assign loc_rdata    = r_loc_rdata;
   assign mbx_in_data  = r_mbx_in_data;
   assign mbx_in_valid = r_mbx_in_valid;

endmodule
